writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_if.sv | 38 +++
 rtl/writeback_queue.sv | 124 ++++++++++++
 tb/tb_writeback_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Bus bundle for writeback_queue: upstream retire port, register-file write port,
// bypass query/result and occupancy.
interface writeback_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_we;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_link;
    logic [4:0]  in_link_rd;
    logic [31:0] in_pc_add4;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  pending;

    modport master (
        output in_valid, in_pc, in_we, in_rd, in_data, in_link, in_link_rd, in_pc_add4,
        output fwd_rs1, fwd_rs2,
        input  in_ready, wb_we, wb_reg, wb_data, wb_pc,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending
    );

    modport slave (
        input  in_valid, in_pc, in_we, in_rd, in_data, in_link, in_link_rd, in_pc_add4,
        input  fwd_rs1, fwd_rs2,
        output in_ready, wb_we, wb_reg, wb_data, wb_pc,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending
    );
endinterface

// File: rtl/writeback_queue.sv
// 4-entry writeback queue: splits a retiring instruction into data/link register writes
// and retires one per cycle. Define WB_QUEUE_FWD_EN to build the bypass lookup.
module writeback_queue (
    input logic                clock,
    input logic                reset,
    writeback_queue_if.slave   bus
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t      mem_q   [4];
    entry_t      mem_d   [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        wb_we_q, wb_we_d;
    entry_t      wb_q, wb_d;

    logic        in_ready;
    logic        accept;
    logic        data_op;
    logic        link_op;
    logic        pop;

    // Readiness from the registered count only: room for a worst-case two-op instruction.
    assign in_ready = (count_q <= 3'd2);

    always_comb begin
        accept   = bus.in_valid && in_ready;
        data_op  = accept && bus.in_we && (bus.in_rd != 5'd0);
        link_op  = accept && bus.in_link && (bus.in_link_rd != 5'd0);
        pop      = (count_q != 3'd0);

        mem_d = mem_q;
        if (data_op) begin
            mem_d[wr_ptr_q] = '{rd: bus.in_rd, data: bus.in_data, pc: bus.in_pc};
        end
        if (link_op) begin
            mem_d[wr_ptr_q + 2'(data_op)] =
                '{rd: bus.in_link_rd, data: bus.in_pc_add4, pc: bus.in_pc};
        end

        wr_ptr_d = wr_ptr_q + 2'(data_op) + 2'(link_op);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q + 3'(data_op) + 3'(link_op) - 3'(pop);

        wb_we_d = pop;
        wb_d    = pop ? mem_q[rd_ptr_q] : wb_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_q     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wb_we_q  <= wb_we_d;
            wb_q     <= wb_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_reg   = wb_q.rd;
    assign bus.wb_data  = wb_q.data;
    assign bus.wb_pc    = wb_q.pc;
    assign bus.pending  = count_q + 3'(wb_we_q);

`ifdef WB_QUEUE_FWD_EN
    // Returns {hit, data}; scans oldest to youngest so the youngest match wins.
    function automatic logic [32:0] lookup(input logic [4:0] rs);
        logic [32:0] res;
        logic [1:0]  idx;
        res = '0;
        if (rs != 5'd0) begin
            if (wb_we_q && (wb_q.rd == rs)) begin
                res = {1'b1, wb_q.data};
            end
            for (int k = 0; k < 4; k++) begin
                idx = rd_ptr_q + 2'(k);
                if ((3'(k) < count_q) && (mem_q[idx].rd == rs)) begin
                    res = {1'b1, mem_q[idx].data};
                end
            end
        end
        return res;
    endfunction

    logic [32:0] fwd1, fwd2;

    always_comb begin
        fwd1 = lookup(bus.fwd_rs1);
        fwd2 = lookup(bus.fwd_rs2);
    end

    assign bus.fwd_hit1  = fwd1[32];
    assign bus.fwd_data1 = fwd1[31:0];
    assign bus.fwd_hit2  = fwd2[32];
    assign bus.fwd_data2 = fwd2[31:0];
`else
    logic unused_fwd;
    assign unused_fwd    = ^{bus.fwd_rs1, bus.fwd_rs2};
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected writes, a negedge
// monitor pops and compares every wb_we pulse and the pending count.
module tb_writeback_queue;

`ifdef WB_QUEUE_FWD_EN
    localparam bit FwdOn = 1'b1;
`else
    localparam bit FwdOn = 1'b0;
`endif

    logic clock;
    logic reset;
    writeback_queue_if bus ();

    writeback_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    bit   saw_not_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pending must equal ops not yet seen on wb_*, and every pulse must match the head.
    always @(negedge clock) begin
        if (!reset) begin
            chk("pending", 32'(bus.pending), 32'(sb.size()));
            if (bus.wb_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb_we", 32'(bus.wb_we), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_reg", 32'(bus.wb_reg), 32'(e.rd));
                    chk("wb_data", bus.wb_data, e.data);
                    chk("wb_pc", bus.wb_pc, e.pc);
                end
            end
        end
    end

    // Drive one instruction and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic link, input logic [4:0] lrd, input logic [31:0] pc);
        bit done;
        done = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_we      = we;
        bus.in_rd      = rd;
        bus.in_data    = data;
        bus.in_link    = link;
        bus.in_link_rd = lrd;
        bus.in_pc      = pc;
        bus.in_pc_add4 = pc + 32'd4;
        for (int c = 0; c < 50 && !done; c++) begin
            if (bus.in_ready) begin
                @(posedge clock);
                #1;
                if (we && rd != 5'd0) sb.push_back('{rd: rd, data: data, pc: pc});
                if (link && lrd != 5'd0) sb.push_back('{rd: lrd, data: pc + 32'd4, pc: pc});
                done = 1'b1;
            end else begin
                saw_not_ready = 1'b1;
                @(posedge clock);
                #1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_we    = 1'b0;
        bus.in_link  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        chk("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        saw_not_ready = 1'b0;
        reset = 1'b1;
        bus.fwd_rs1 = 5'd0;
        bus.fwd_rs2 = 5'd0;
        bus.in_pc = '0;
        bus.in_rd = '0;
        bus.in_data = '0;
        bus.in_link_rd = '0;
        bus.in_pc_add4 = '0;
        idle();

        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_fwd_hit1", 32'(bus.fwd_hit1), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single write with latency check.
        send(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h100);
        idle();
        chk("lat_edgeN_wb_we", 32'(bus.wb_we), 32'd0);
        @(posedge clock);
        #1;
        chk("lat_edgeN1_wb_we", 32'(bus.wb_we), 32'd1);
        chk("lat_edgeN1_wb_reg", 32'(bus.wb_reg), 32'd5);
        @(posedge clock);
        #1;
        chk("lat_after_wb_we", 32'(bus.wb_we), 32'd0);
        chk("hold_wb_data", bus.wb_data, 32'hDEADBEEF);
        drain();

        // Dual op: data then link.
        send(1'b1, 5'd3, 32'h11, 1'b1, 5'd31, 32'h200);
        idle();
        drain();

        // Register 0 dropped; mixed case keeps only the data op.
        send(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h300);
        idle();
        drain();
        send(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 32'h304);
        idle();
        drain();

        // Backpressure across pointer wrap.
        saw_not_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 5'(i + 1), 32'hA0 + 32'(i), 1'b1, 5'(20 + i), 32'h400 + 32'(8 * i));
        end
        idle();
        chk("backpressure_seen", 32'(saw_not_ready), 32'd1);
        drain();

        // Bypass: youngest of two writes to r7.
        send(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h500);
        send(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h504);
        idle();
        bus.fwd_rs1 = 5'd7;
        bus.fwd_rs2 = 5'd0;
        #1;
        chk("fwd_hit1", 32'(bus.fwd_hit1), 32'(FwdOn));
        chk("fwd_data1", bus.fwd_data1, FwdOn ? 32'h2 : 32'h0);
        chk("fwd_hit2_r0", 32'(bus.fwd_hit2), 32'd0);
        bus.fwd_rs1 = 5'd0;
        drain();

        // Reset mid-drain discards everything.
        send(1'b1, 5'd10, 32'hC0, 1'b1, 5'd11, 32'h600);
        send(1'b1, 5'd12, 32'hC2, 1'b0, 5'd0, 32'h604);
        idle();
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_wb_we", 32'(bus.wb_we), 32'd0);
        chk("mid_rst_pending", 32'(bus.pending), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("post_rst_wb_we", 32'(bus.wb_we), 32'd0);
        chk("post_rst_pending", 32'(bus.pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
